data_mem_responder: RTL

Memory-side responder for the CPU's data-memory port: it accepts one load or store request at a time over a valid/ready handshake, performs the access on a word-organised internal RAM with byte/halfword/word sizing, and returns a single response over a second valid/ready handshake. It sits on the far side of the data-memory interface, behind the ALU-address/store-data path of the CPU's MEM stage. The wait-state count is configurable so pipeline stall handling can be exercised against a slow memory.

---
 rtl/data_mem_responder.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a configurable
// number of cycles, performs a byte/halfword/word access on a word-organised RAM
// and returns a single registered response.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // Latched request
    logic                  r_we;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [31:0]           r_wdata;

    // Wait-state counter and registered response
    logic [3:0]  r_waitCnt;
    logic        r_rspValid;
    logic [31:0] r_rspRdata;
    logic        r_rspErr;

    // Word-organised storage; deliberately not reset
    logic [31:0] r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_access;
    logic                  w_rspDone;
    logic [ADDR_WIDTH-1:0] w_wordIdx;
    logic [1:0]            w_byteOff;
    logic                  w_err;
    logic [31:0]           w_memWord;
    logic [7:0]            w_byteSel;
    logic [15:0]           w_halfSel;
    logic [31:0]           w_loadData;
    logic [3:0]            w_byteEn;
    logic [31:0]           w_storeData;
    logic                  w_write;
    logic                  w_unusedAddrBits;

    // Address bits above the RAM size only alias, so they are intentionally dropped
    assign w_unusedAddrBits = ^req_addr[31:ADDR_WIDTH+2];

    assign w_accept  = (r_state == ST_IDLE) && req_valid;
    assign w_access  = (r_state == ST_WAIT) && (r_waitCnt == 4'd0);
    assign w_rspDone = (r_state == ST_RESP) && rsp_ready;

    assign w_wordIdx = r_addr[ADDR_WIDTH+1:2];
    assign w_byteOff = r_addr[1:0];
    assign w_memWord = r_mem[w_wordIdx];
    assign w_write   = w_access && r_we && !w_err;

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rspValid;
    assign rsp_rdata = r_rspRdata;
    assign rsp_err   = r_rspErr;

    // Flag illegal sizes and accesses that are not naturally aligned
    always_comb begin
        w_err = 1'b0;
        case (r_size)
            SIZE_BYTE: w_err = 1'b0;
            SIZE_HALF: w_err = w_byteOff[0];
            SIZE_WORD: w_err = (w_byteOff != 2'b00);
            default:   w_err = 1'b1;
        endcase
    end

    // Pick the addressed little-endian lanes and extend them to 32 bits
    always_comb begin
        w_byteSel  = 8'h00;
        w_halfSel  = 16'h0000;
        w_loadData = 32'h0000_0000;
        case (w_byteOff)
            2'd0:    w_byteSel = w_memWord[7:0];
            2'd1:    w_byteSel = w_memWord[15:8];
            2'd2:    w_byteSel = w_memWord[23:16];
            default: w_byteSel = w_memWord[31:24];
        endcase
        w_halfSel = w_byteOff[1] ? w_memWord[31:16] : w_memWord[15:0];
        case (r_size)
            SIZE_BYTE: w_loadData = {{24{r_signed & w_byteSel[7]}}, w_byteSel};
            SIZE_HALF: w_loadData = {{16{r_signed & w_halfSel[15]}}, w_halfSel};
            SIZE_WORD: w_loadData = w_memWord;
            default:   w_loadData = 32'h0000_0000;
        endcase
    end

    // Replicate right-aligned store data across lanes and enable only the target lanes
    always_comb begin
        w_byteEn    = 4'b0000;
        w_storeData = 32'h0000_0000;
        case (r_size)
            SIZE_BYTE: begin
                w_byteEn    = 4'b0001 << w_byteOff;
                w_storeData = {4{r_wdata[7:0]}};
            end
            SIZE_HALF: begin
                w_byteEn    = w_byteOff[1] ? 4'b1100 : 4'b0011;
                w_storeData = {2{r_wdata[15:0]}};
            end
            SIZE_WORD: begin
                w_byteEn    = 4'b1111;
                w_storeData = r_wdata;
            end
            default: begin
                w_byteEn    = 4'b0000;
                w_storeData = 32'h0000_0000;
            end
        endcase
    end

    // Byte-lane RAM write at the access edge
    always_ff @(posedge clk) begin
        if (w_write) begin
            for (int k = 0; k < 4; k++) begin
                if (w_byteEn[k]) begin
                    r_mem[w_wordIdx][8*k +: 8] <= w_storeData[8*k +: 8];
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode: one request in flight, response must be taken before the next accept
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (req_valid)          w_nextState = ST_WAIT;
            ST_WAIT: if (r_waitCnt == 4'd0)  w_nextState = ST_RESP;
            ST_RESP: if (rsp_ready)          w_nextState = ST_IDLE;
            default:                         w_nextState = ST_IDLE;
        endcase
    end

    // Capture the request at accept time so the access uses stable fields
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_wdata  <= 32'h0000_0000;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_addr   <= req_addr[ADDR_WIDTH+1:0];
            r_size   <= req_size;
            r_signed <= req_signed;
            r_wdata  <= req_wdata;
        end
    end

    // Wait-state counter: loaded on accept, counts down to the access edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_waitCnt <= 4'd0;
        end else if (w_accept) begin
            r_waitCnt <= WAIT_INIT;
        end else if ((r_state == ST_WAIT) && (r_waitCnt != 4'd0)) begin
            r_waitCnt <= r_waitCnt - 4'd1;
        end
    end

    // Registered response: set at the access edge, held through backpressure, cleared on handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rspValid <= 1'b0;
            r_rspRdata <= 32'h0000_0000;
            r_rspErr   <= 1'b0;
        end else if (w_access) begin
            r_rspValid <= 1'b1;
            r_rspRdata <= (w_err || r_we) ? 32'h0000_0000 : w_loadData;
            r_rspErr   <= w_err;
        end else if (w_rspDone) begin
            r_rspValid <= 1'b0;
            r_rspRdata <= 32'h0000_0000;
            r_rspErr   <= 1'b0;
        end
    end

endmodule
